// File: rtl/program_loader.sv
// Streams a program into core program memory, holds the core in reset while loading, then
// releases and supervises it. Define LOADER_WATCHDOG_EN to add the RUN-phase watchdog.
module program_loader #(
  parameter int ADDR       = 8,
  parameter int CODE       = 4,
  parameter int WORD       = ADDR + CODE,
  parameter int WDT_CYCLES = 1024
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_start,
  input  logic [ADDR-1:0] load_len,
  input  logic            run_start,
  input  logic            abort,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [WORD-1:0] in_data,
  output logic            rom_we,
  output logic [ADDR-1:0] rom_addr,
  output logic [WORD-1:0] rom_data,
  output logic            core_rst,
  input  logic            flag_f,
  output logic            busy,
  output logic            done,
  output logic            timeout
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_WRITE   = 3'd2,
    S_RELEASE = 3'd3,
    S_RUN     = 3'd4,
    S_HALT    = 3'd5
  } state_t;

  state_t          state_r;
  state_t          state_next_s;
  logic [ADDR-1:0] len_r;
  logic [ADDR-1:0] rom_addr_r;
  logic [WORD-1:0] rom_data_r;
  logic            rel_r;
  logic            in_ready_r;
  logic            rom_we_r;
  logic            core_rst_r;
  logic            busy_r;
  logic            done_r;
  logic            last_word_s;
  logic            start_load_s;
  logic            wdt_hit_s;

  // The write address doubles as the word counter; len-1 wraps so len=0 means 2^ADDR words.
  assign last_word_s  = (rom_addr_r == (len_r - ADDR'(1)));
  assign start_load_s = ((state_r == S_IDLE) || (state_r == S_HALT)) && (state_next_s == S_LOAD);

  // Next-state decode; abort overrides every other event.
  always_comb begin
    state_next_s = state_r;
    if (abort) begin
      state_next_s = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE:    state_next_s = load_start ? S_LOAD : S_IDLE;
        S_LOAD:    state_next_s = in_valid ? S_WRITE : S_LOAD;
        S_WRITE:   state_next_s = last_word_s ? S_RELEASE : S_LOAD;
        S_RELEASE: state_next_s = rel_r ? S_RUN : S_RELEASE;
        S_RUN:     state_next_s = (flag_f || wdt_hit_s) ? S_HALT : S_RUN;
        S_HALT:    state_next_s = load_start ? S_LOAD : (run_start ? S_RELEASE : S_HALT);
        default:   state_next_s = S_IDLE;
      endcase
    end
  end

  // State register and outputs registered from the next state so they match the state they describe.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= S_IDLE;
      rel_r      <= 1'b0;
      in_ready_r <= 1'b0;
      rom_we_r   <= 1'b0;
      core_rst_r <= 1'b1;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      rel_r      <= (state_r == S_RELEASE) && (state_next_s == S_RELEASE);
      in_ready_r <= (state_next_s == S_LOAD);
      rom_we_r   <= (state_next_s == S_WRITE);
      core_rst_r <= (state_next_s != S_RUN);
      busy_r     <= (state_next_s == S_LOAD) || (state_next_s == S_WRITE) ||
                    (state_next_s == S_RELEASE) || (state_next_s == S_RUN);
      done_r     <= (state_next_s == S_HALT);
    end
  end

  // Load datapath: length latch, address/counter, and captured program word.
  always_ff @(posedge clk) begin
    if (!rst) begin
      len_r      <= {ADDR{1'b0}};
      rom_addr_r <= {ADDR{1'b0}};
      rom_data_r <= {WORD{1'b0}};
    end else begin
      if (start_load_s) begin
        len_r      <= load_len;
        rom_addr_r <= {ADDR{1'b0}};
      end else if ((state_r == S_WRITE) && (state_next_s == S_LOAD)) begin
        len_r      <= len_r;
        rom_addr_r <= rom_addr_r + ADDR'(1);
      end else begin
        len_r      <= len_r;
        rom_addr_r <= rom_addr_r;
      end
      if ((state_r == S_LOAD) && (state_next_s == S_WRITE)) begin
        rom_data_r <= in_data;
      end else begin
        rom_data_r <= rom_data_r;
      end
    end
  end

`ifdef LOADER_WATCHDOG_EN
  localparam int WDT_W = $clog2(WDT_CYCLES + 1);
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);

  logic [WDT_W-1:0] wdt_r;
  logic             timeout_r;

  assign wdt_hit_s = (wdt_r == WDT_LAST);
  assign timeout   = timeout_r;

  // RUN cycle counter; sits at zero outside RUN so it is clear on every RUN entry.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wdt_r <= {WDT_W{1'b0}};
    end else if (state_r == S_RUN) begin
      wdt_r <= wdt_r + WDT_W'(1);
    end else begin
      wdt_r <= {WDT_W{1'b0}};
    end
  end

  // Timeout flag: a simultaneous flag_f counts as a normal halt.
  always_ff @(posedge clk) begin
    if (!rst) begin
      timeout_r <= 1'b0;
    end else if (abort) begin
      timeout_r <= 1'b0;
    end else if ((state_r == S_RUN) && (state_next_s == S_HALT)) begin
      timeout_r <= wdt_hit_s && !flag_f;
    end else if ((state_next_s == S_LOAD) || (state_next_s == S_RELEASE)) begin
      timeout_r <= 1'b0;
    end else begin
      timeout_r <= timeout_r;
    end
  end
`else
  assign wdt_hit_s = 1'b0;
  assign timeout   = 1'b0;
`endif

  assign in_ready = in_ready_r;
  assign rom_we   = rom_we_r;
  assign rom_addr = rom_addr_r;
  assign rom_data = rom_data_r;
  assign core_rst = core_rst_r;
  assign busy     = busy_r;
  assign done     = done_r;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: random programs are compared against an
// expected write list built from the load rules (address i receives word i).
module tb_program_loader;
  localparam int ADDR = 8;
  localparam int CODE = 4;
  localparam int WORD = ADDR + CODE;
  localparam int WDT  = 8;
`ifdef LOADER_WATCHDOG_EN
  localparam int FLAG_CYC = 5;
`else
  localparam int FLAG_CYC = 10;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic load_start = 1'b0;
  logic run_start = 1'b0;
  logic abort = 1'b0;
  logic in_valid = 1'b0;
  logic flag_f = 1'b0;
  logic [ADDR-1:0] load_len = '0;
  logic [WORD-1:0] in_data = '0;
  logic in_ready, rom_we, core_rst, busy, done, timeout;
  logic [ADDR-1:0] rom_addr;
  logic [WORD-1:0] rom_data;

  int errors = 0;
  int checks = 0;
  int fed = 0;
  logic [WORD-1:0]      prog[$];
  logic [ADDR+WORD-1:0] cap_q[$];
  logic [ADDR+WORD-1:0] exp_q[$];

  program_loader #(.ADDR(ADDR), .CODE(CODE), .WORD(WORD), .WDT_CYCLES(WDT)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .load_len(load_len),
    .run_start(run_start), .abort(abort), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .rom_we(rom_we), .rom_addr(rom_addr), .rom_data(rom_data),
    .core_rst(core_rst), .flag_f(flag_f), .busy(busy), .done(done), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Write monitor: records every strobe and checks it never overlaps in_ready.
  always @(negedge clk) begin
    if (rom_we === 1'b1) begin
      cap_q.push_back({rom_addr, rom_data});
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL we_ready_overlap: in_ready=%b while rom_we=1, required 0", in_ready);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b0; in_valid = 1'b0; load_start = 1'b0; run_start = 1'b0;
    abort = 1'b0; flag_f = 1'b0;
    tick; tick;
    rst = 1'b1;
    cap_q.delete();
  endtask

  task automatic make_random(input int n);
    prog.delete();
    for (int i = 0; i < n; i++) prog.push_back(WORD'($urandom));
  endtask

  // Reference model: word i of the program lands at address i mod 2^ADDR, in order.
  task automatic make_expected(input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back({ADDR'(i), prog[i]});
  endtask

  function automatic int first_mismatch();
    if (cap_q.size() != exp_q.size()) return -2;
    foreach (exp_q[i]) if (cap_q[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  task automatic start_load(input logic [ADDR-1:0] len_field);
    fed = 0;
    cap_q.delete();
    load_start = 1'b1; load_len = len_field;
    tick;
    load_start = 1'b0;
  endtask

  // Offers words until 'upto' are accepted; mode 1 randomises in_valid, gap_at inserts a
  // 5-cycle valid gap with ignored load_start/run_start noise.
  task automatic feed(input int upto, input int mode, input int gap_at);
    int gapc = 0;
    int budget = 4000;
    logic give, acc;
    while (fed < upto && budget > 0) begin
      give = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (fed == gap_at && gapc < 5) begin
        give = 1'b0; gapc++;
        load_start = 1'b1; run_start = 1'b1; load_len = 8'd1;
      end else begin
        load_start = 1'b0; run_start = 1'b0;
      end
      in_valid = give; in_data = prog[fed];
      acc = give && in_ready;
      tick;
      if (acc) fed++;
      budget--;
    end
    in_valid = 1'b0; load_start = 1'b0; run_start = 1'b0;
    if (fed < upto) begin
      errors++; checks++;
      $display("FAIL feed_timeout: accepted %0d words, required %0d", fed, upto);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    tick; tick;
    checks++;
    if ({core_rst, in_ready, rom_we, busy, done, timeout} !== 6'b100000 ||
        rom_addr !== 8'd0 || rom_data !== 12'd0)
      begin errors++; $display("FAIL reset_state: got %b addr %h data %h, required 100000 00 000",
        {core_rst, in_ready, rom_we, busy, done, timeout}, rom_addr, rom_data); end
    rst = 1'b1;
  endtask

  task automatic test_basic;
    int r;
    do_reset;
    prog = {12'h101, 12'h202, 12'h303};
    make_expected(3);
    start_load(8'd3);
    checks++;
    if ({in_ready, busy, core_rst} !== 3'b111)
      begin errors++; $display("FAIL load_entry: got %b, required 111", {in_ready, busy, core_rst}); end
    feed(3, 0, -1);
    checks++;
    if (rom_we !== 1'b1 || rom_addr !== 8'd2 || rom_data !== 12'h303)
      begin errors++; $display("FAIL last_write: we %b addr %h data %h, required 1 02 303", rom_we, rom_addr, rom_data); end
    for (int c = 1; c <= 2; c++) begin
      tick;
      checks++;
      if ({core_rst, busy, rom_we, in_ready} !== 4'b1100)
        begin errors++; $display("FAIL release_%0d: got %b, required 1100", c, {core_rst, busy, rom_we, in_ready}); end
    end
    tick;
    checks++;
    if ({core_rst, busy, done} !== 3'b010)
      begin errors++; $display("FAIL run_entry: got %b, required 010", {core_rst, busy, done}); end
    r = first_mismatch();
    checks++;
    if (r != -1)
      begin errors++; $display("FAIL writes_basic: %0d writes first bad %0d, required %0d matching", cap_q.size(), r, exp_q.size()); end
  endtask

  task automatic test_run_halt;
    int bad = 0;
    int n;
    for (int c = 2; c <= FLAG_CYC; c++) begin
      tick;
      if (core_rst !== 1'b0 || busy !== 1'b1 || done !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL run_hold: %0d bad RUN cycles, required 0", bad); end
    flag_f = 1'b1;
    tick;
    flag_f = 1'b0;
    checks++;
    if ({core_rst, done, busy, timeout} !== 4'b1100)
      begin errors++; $display("FAIL halt_entry: got %b, required 1100", {core_rst, done, busy, timeout}); end
    n = cap_q.size();
    run_start = 1'b1;
    tick;
    run_start = 1'b0;
    checks++;
    if ({core_rst, busy, done, rom_we} !== 4'b1100)
      begin errors++; $display("FAIL rerun_release: got %b, required 1100", {core_rst, busy, done, rom_we}); end
    tick; tick;
    checks++;
    if (core_rst !== 1'b0 || cap_q.size() != n || rom_data !== 12'h303)
      begin errors++; $display("FAIL rerun_run: core_rst %b writes %0d data %h, required 0 %0d 303", core_rst, cap_q.size(), rom_data, n); end
  endtask

  task automatic test_halt_priority;
    int r;
    flag_f = 1'b1;
    tick;
    flag_f = 1'b0;
    make_random(4);
    make_expected(4);
    fed = 0;
    cap_q.delete();
    load_start = 1'b1; run_start = 1'b1; load_len = 8'd4;
    tick;
    load_start = 1'b0; run_start = 1'b0;
    checks++;
    if ({in_ready, done, busy, core_rst} !== 4'b1011)
      begin errors++; $display("FAIL halt_load_wins: got %b, required 1011", {in_ready, done, busy, core_rst}); end
    feed(4, 1, -1);
    tick; tick; tick;
    r = first_mismatch();
    checks++;
    if (r != -1 || core_rst !== 1'b0)
      begin errors++; $display("FAIL writes_reload: core_rst %b first bad %0d, required 0 -1", core_rst, r); end
  endtask

  task automatic test_gap;
    int n, r;
    do_reset;
    n = $urandom_range(6, 12);
    make_random(n);
    make_expected(n);
    start_load(ADDR'(n));
    feed(n, 0, 3);
    tick; tick; tick;
    r = first_mismatch();
    checks++;
    if (r != -1 || core_rst !== 1'b0)
      begin errors++; $display("FAIL writes_gap: core_rst %b %0d writes first bad %0d, required 0 %0d -1", core_rst, cap_q.size(), r, n); end
  endtask

  task automatic test_abort;
    int r;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    make_random(5);
    make_expected(2);
    start_load(8'd5);
    feed(2, 0, -1);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    checks++;
    if ({core_rst, in_ready, rom_we, busy, done, timeout} !== 6'b100000)
      begin errors++; $display("FAIL abort_write: got %b, required 100000", {core_rst, in_ready, rom_we, busy, done, timeout}); end
    tick;
    r = first_mismatch();
    checks++;
    if (r != -1) begin errors++; $display("FAIL abort_writes: %0d writes first bad %0d, required 2", cap_q.size(), r); end
    run_start = 1'b1;
    tick;
    run_start = 1'b0;
    checks++;
    if ({busy, core_rst, in_ready} !== 3'b010)
      begin errors++; $display("FAIL idle_run_ignored: got %b, required 010", {busy, core_rst, in_ready}); end
  endtask

  task automatic test_reset_mid;
    int n;
    do_reset;
    make_random(6);
    start_load(8'd6);
    feed(2, 0, -1);
    tick;
    rst = 1'b0;
    tick;
    checks++;
    if ({core_rst, in_ready, rom_we, busy, done, timeout} !== 6'b100000 || rom_addr !== 8'd0 || rom_data !== 12'd0)
      begin errors++; $display("FAIL reset_mid_load: got %b addr %h data %h, required 100000 00 000",
        {core_rst, in_ready, rom_we, busy, done, timeout}, rom_addr, rom_data); end
    rst = 1'b1;
    n = cap_q.size();
    in_valid = 1'b1;
    tick; tick; tick; tick;
    in_valid = 1'b0;
    checks++;
    if (cap_q.size() != n || busy !== 1'b0)
      begin errors++; $display("FAIL reset_no_write: writes %0d busy %b, required %0d 0", cap_q.size(), busy, n); end
    make_random(2);
    start_load(8'd2);
    feed(2, 0, -1);
    tick; tick; tick; tick;
    rst = 1'b0;
    tick;
    rst = 1'b1;
    checks++;
    if ({core_rst, busy, rom_we, done} !== 4'b1000)
      begin errors++; $display("FAIL reset_mid_run: got %b, required 1000", {core_rst, busy, rom_we, done}); end
  endtask

  task automatic test_len_zero;
    int r;
    do_reset;
    make_random(1 << ADDR);
    make_expected(1 << ADDR);
    start_load(8'd0);
    feed(1 << ADDR, 1, -1);
    checks++;
    if (rom_we !== 1'b1 || rom_addr !== 8'hFF)
      begin errors++; $display("FAIL len0_last: we %b addr %h, required 1 ff", rom_we, rom_addr); end
    tick;
    checks++;
    if ({core_rst, busy, rom_we, in_ready} !== 4'b1100)
      begin errors++; $display("FAIL len0_release: got %b, required 1100", {core_rst, busy, rom_we, in_ready}); end
    r = first_mismatch();
    checks++;
    if (r != -1) begin errors++; $display("FAIL writes_len0: %0d writes first bad %0d, required 256", cap_q.size(), r); end
  endtask

  task automatic test_watchdog;
    int bad = 0;
    do_reset;
    make_random(2);
    start_load(8'd2);
    feed(2, 0, -1);
    tick; tick; tick;
`ifdef LOADER_WATCHDOG_EN
    for (int c = 2; c <= WDT; c++) begin
      tick;
      if (core_rst !== 1'b0) bad++;
    end
    tick;
    checks++;
    if (bad != 0 || {done, timeout, core_rst} !== 3'b111)
      begin errors++; $display("FAIL wdt_expire: bad %0d got %b, required 0 111", bad, {done, timeout, core_rst}); end
    run_start = 1'b1;
    tick;
    run_start = 1'b0;
    checks++;
    if ({timeout, done} !== 2'b00)
      begin errors++; $display("FAIL wdt_clear: got %b, required 00", {timeout, done}); end
    tick; tick;
    for (int c = 2; c <= WDT; c++) tick;
    flag_f = 1'b1;
    tick;
    flag_f = 1'b0;
    checks++;
    if ({done, timeout} !== 2'b10)
      begin errors++; $display("FAIL wdt_flag_same: got %b, required 10", {done, timeout}); end
`else
    for (int c = 2; c <= 120; c++) begin
      tick;
      if (core_rst !== 1'b0 || timeout !== 1'b0 || done !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL run_persist: %0d bad cycles, required 0", bad); end
    flag_f = 1'b1;
    tick;
    flag_f = 1'b0;
`endif
    abort = 1'b1;
    tick;
    abort = 1'b0;
    checks++;
    if ({done, timeout, busy, core_rst} !== 4'b0001)
      begin errors++; $display("FAIL abort_halt: got %b, required 0001", {done, timeout, busy, core_rst}); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_run_halt;
    test_halt_priority;
    test_gap;
    test_abort;
    test_reset_mid;
    test_len_zero;
    test_watchdog;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
